// File: rtl/value_digit_render.sv
// Renders the R/G/B channel values as a 3x3 grid of decimal glyphs; values are
// converted once per frame by a double-dabble FSM and shown through a 2-stage pixel pipe.
module value_digit_render #(
  parameter logic [9:0] X0 = 10'd64,
  parameter logic [9:0] Y0 = 10'd64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic [7:0]  val_r,
  input  logic [7:0]  val_g,
  input  logic [7:0]  val_b,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        video_on,
  output logic [3:0]  glyph_digit,
  output logic [3:0]  glyph_row,
  input  logic [15:0] glyph_bits,
  output logic [11:0] rgb,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, NEXT, COMMIT} state_t;

  state_t state_q, state_d;
  logic [1:0]  ch_q, ch_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  bin_q, bin_d;
  logic [11:0] scr_q, scr_d;
  logic [11:0] adj;
  logic [7:0]  cap_g_q, cap_g_d, cap_b_q, cap_b_d;
  // [line][cell][bcd]; cell 0 is the hundreds digit
  logic [2:0][2:0][3:0] wrk_q, wrk_d, disp_q, disp_d;

  logic [9:0]  x_q, x_d, y_q, y_d;
  logic        von_q, von_d;
  logic [11:0] rgb_q, rgb_d;
  logic [9:0]  dx, dy;
  logic        in_region;

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    cap_g_d = cap_g_q;
    cap_b_d = cap_b_q;
    wrk_d   = wrk_q;
    disp_d  = disp_q;
    for (int i = 0; i < 3; i++) begin
      adj[4*i +: 4] = (scr_q[4*i +: 4] >= 4'd5) ? scr_q[4*i +: 4] + 4'd3 : scr_q[4*i +: 4];
    end
    case (state_q)
      IDLE: begin
        if (frame_start) state_d = LOAD;
      end
      LOAD: begin
        cap_g_d = val_g;
        cap_b_d = val_b;
        bin_d   = val_r;
        ch_d    = 2'd0;
        scr_d   = 12'd0;
        cnt_d   = 4'd8;
        state_d = SHIFT;
      end
      SHIFT: begin
        scr_d = {adj[10:0], bin_q[7]};
        bin_d = {bin_q[6:0], 1'b0};
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = NEXT;
      end
      NEXT: begin
        wrk_d[ch_q][0] = scr_q[11:8];
        wrk_d[ch_q][1] = scr_q[7:4];
        wrk_d[ch_q][2] = scr_q[3:0];
        if (ch_q == 2'd2) begin
          state_d = COMMIT;
        end else begin
          // reload for the next channel directly, skipping a separate LOAD cycle
          ch_d    = ch_q + 2'd1;
          bin_d   = (ch_q == 2'd0) ? cap_g_q : cap_b_q;
          scr_d   = 12'd0;
          cnt_d   = 4'd8;
          state_d = SHIFT;
        end
      end
      COMMIT: begin
        disp_d  = wrk_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    x_d       = pixel_x;
    y_d       = pixel_y;
    von_d     = video_on;
    dx        = x_q - X0;
    dy        = y_q - Y0;
    in_region = von_q && (dx < 10'd48) && (dy < 10'd48);
    glyph_digit = 4'd0;
    glyph_row   = 4'd0;
    rgb_d       = 12'h000;
    if (in_region) begin
      glyph_digit = disp_q[dy[5:4]][dx[5:4]];
      glyph_row   = dy[3:0];
      // bit 15 is the leftmost pixel, so column n maps to bit ~n
      if (glyph_bits[~dx[3:0]]) begin
        case (dy[5:4])
          2'd0:    rgb_d = 12'hF00;
          2'd1:    rgb_d = 12'h0F0;
          default: rgb_d = 12'h00F;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ch_q    <= 2'd0;
      cnt_q   <= 4'd0;
      bin_q   <= 8'd0;
      scr_q   <= 12'd0;
      cap_g_q <= 8'd0;
      cap_b_q <= 8'd0;
      wrk_q   <= '0;
      disp_q  <= '0;
      x_q     <= 10'd0;
      y_q     <= 10'd0;
      von_q   <= 1'b0;
      rgb_q   <= 12'h000;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      cap_g_q <= cap_g_d;
      cap_b_q <= cap_b_d;
      wrk_q   <= wrk_d;
      disp_q  <= disp_d;
      x_q     <= x_d;
      y_q     <= y_d;
      von_q   <= von_d;
      rgb_q   <= rgb_d;
    end
  end

  assign rgb  = rgb_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_value_digit_render.sv
// Scoreboard bench for value_digit_render: stimulus queues expected outputs by due cycle,
// a negedge monitor compares them.
module tb_value_digit_render;

  localparam logic [9:0] X0 = 10'd64;
  localparam logic [9:0] Y0 = 10'd64;

  logic        clk = 1'b0;
  logic        rst, frame_start, video_on;
  logic [7:0]  val_r, val_g, val_b;
  logic [9:0]  pixel_x, pixel_y;
  logic [3:0]  glyph_digit, glyph_row;
  logic [15:0] glyph_bits, rom_val;
  logic [11:0] rgb;
  logic        busy;

  value_digit_render #(.X0(X0), .Y0(Y0)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .val_r(val_r), .val_g(val_g), .val_b(val_b),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
    .glyph_digit(glyph_digit), .glyph_row(glyph_row), .glyph_bits(glyph_bits),
    .rgb(rgb), .busy(busy)
  );

  always #5 clk = ~clk;
  assign glyph_bits = rom_val;

  typedef struct {
    int          due;
    int          kind;   // 0 rgb, 1 glyph_digit, 2 glyph_row, 3 busy
    logic [11:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [11:0] act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        case (sb[i].kind)
          0:       act = rgb;
          1:       act = {8'd0, glyph_digit};
          2:       act = {8'd0, glyph_row};
          default: act = {11'd0, busy};
        endcase
        checks++;
        if (act !== sb[i].exp) begin
          errors++;
          $display("FAIL %s cyc %0d got %h expected %h", sb[i].name, cyc, act, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  task automatic push(input int due, input int kind, input logic [11:0] exp, input string name);
    exp_t e;
    e.due = due; e.kind = kind; e.exp = exp; e.name = name;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pixel(input logic [9:0] x, input logic [9:0] y, input logic von,
                       input logic [11:0] e_rgb, input logic [3:0] e_dig,
                       input logic [3:0] e_row, input string name);
    pixel_x = x; pixel_y = y; video_on = von;
    push(cyc + 1, 1, {8'd0, e_dig}, {name, "_digit"});
    push(cyc + 1, 2, {8'd0, e_row}, {name, "_row"});
    push(cyc + 2, 0, e_rgb, {name, "_rgb"});
    step();
  endtask

  task automatic start(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                       input bit full);
    val_r = r; val_g = g; val_b = b; frame_start = 1'b1;
    push(cyc, 3, 12'd0, "busy_before");
    push(cyc + 1, 3, 12'd1, "busy_first");
    if (full) begin
      push(cyc + 29, 3, 12'd1, "busy_last");
      push(cyc + 30, 3, 12'd0, "busy_done");
    end
    step();
    frame_start = 1'b0;
  endtask

  // rom_val must stay 16'h8000 here: dx[3:0] is 0 so every cell lights in its line colour
  task automatic sweep(input int d [9], input string name);
    logic [11:0] col [3];
    col[0] = 12'hF00; col[1] = 12'h0F0; col[2] = 12'h00F;
    for (int l = 0; l < 3; l++)
      for (int c = 0; c < 3; c++)
        pixel(X0 + 10'(16 * c), Y0 + 10'(16 * l + 3), 1'b1, col[l], 4'(d[l * 3 + c]), 4'd3, name);
  endtask

  initial begin
    int d_a [9]  = '{2, 5, 5, 1, 2, 8, 0, 0, 0};
    int d_b [9]  = '{0, 0, 7, 0, 4, 2, 1, 9, 9};
    int d_z [9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    int d_c [9]  = '{0, 0, 9, 0, 9, 9, 1, 0, 0};

    rst = 1'b1; frame_start = 1'b0; video_on = 1'b0;
    val_r = 8'd0; val_g = 8'd0; val_b = 8'd0;
    pixel_x = 10'd0; pixel_y = 10'd0; rom_val = 16'h8000;
    idle(2);
    push(cyc, 3, 12'd0, "reset_busy");
    push(cyc, 0, 12'h000, "reset_rgb");
    push(cyc, 1, 12'd0, "reset_digit");
    push(cyc, 2, 12'd0, "reset_row");
    frame_start = 1'b1;
    push(cyc + 1, 3, 12'd0, "rst_over_frame_start");
    step();
    frame_start = 1'b0;
    rst = 1'b0;
    push(cyc + 1, 3, 12'd0, "rst_over_frame_start_after");
    step();

    // 255/128/0
    start(8'd255, 8'd128, 8'd0, 1'b1);
    idle(31);
    sweep(d_a, "conv_a");
    pixel(X0 + 10'd16, Y0, 1'b1, 12'hF00, 4'd5, 4'd0, "r_tens_lit");
    pixel(X0 + 10'd17, Y0, 1'b1, 12'h000, 4'd5, 4'd0, "r_tens_col1");

    idle(2);
    rom_val = 16'hFFFF;
    pixel(X0 + 10'd47, Y0 + 10'd47, 1'b1, 12'h00F, 4'd0, 4'd15, "corner");
    pixel(X0 + 10'd48, Y0, 1'b1, 12'h000, 4'd0, 4'd0, "right_edge");
    pixel(X0 - 10'd1, Y0, 1'b1, 12'h000, 4'd0, 4'd0, "left_edge");
    pixel(X0 + 10'd5, Y0 + 10'd20, 1'b0, 12'h000, 4'd0, 4'd0, "video_off");
    pixel(X0 + 10'd5, Y0 + 10'd20, 1'b1, 12'h0F0, 4'd1, 4'd4, "g_hundreds");
    pixel(X0 + 10'd20, Y0 - 10'd1, 1'b1, 12'h000, 4'd0, 4'd0, "top_edge");

    // ignored second frame_start, display held until commit
    idle(2);
    rom_val = 16'h8000;
    start(8'd7, 8'd42, 8'd199, 1'b1);
    idle(4);
    val_r = 8'd1; val_g = 8'd2; val_b = 8'd3; frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    pixel(X0, Y0, 1'b1, 12'hF00, 4'd2, 4'd0, "hold_r_hundreds");
    pixel(X0 + 10'd32, Y0 + 10'd16, 1'b1, 12'h0F0, 4'd8, 4'd0, "hold_g_units");
    idle(25);
    sweep(d_b, "conv_b");

    // reset during G SHIFT step 4
    idle(2);
    start(8'd50, 8'd60, 8'd70, 1'b0);
    idle(13);
    rst = 1'b1;
    push(cyc + 1, 3, 12'd0, "abort_busy");
    step();
    rst = 1'b0;
    push(cyc + 5, 3, 12'd0, "abort_stays_idle");
    idle(1);
    sweep(d_z, "abort");
    start(8'd9, 8'd99, 8'd100, 1'b1);
    idle(31);
    sweep(d_c, "conv_c");

    idle(4);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left %0d required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
